// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adder_seq_ctrl
// Brief    : Button-driven operand sequencer for the 4-bit adder plus a
//            multiplexed 4-digit seven-segment scanner showing A, B and sum.
// Revision : 1.0 - initial release
// ============================================================================
module adder_seq_ctrl #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [4:0] sum,
  output logic [1:0] state,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] C_DIV_LAST = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    ST_WAIT_A = 2'b00,
    ST_WAIT_B = 2'b01,
    ST_SHOW   = 2'b10,
    ST_BAD    = 2'b11
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_op_a, r_op_b, w_op_a_nxt, w_op_b_nxt;
  logic             r_s1, r_s2, r_s3;
  logic             w_press;
  logic [CNT_W-1:0] r_div_cnt;
  logic [1:0]       r_digit_idx;
  logic             w_digit_on;
  logic [3:0]       w_digit_val;
  logic [6:0]       w_seg_dec;

  // Synchronizer presets high so a button held through reset never fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_press = r_s2 & ~r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAIT_A;
      r_op_a  <= 4'h0;
      r_op_b  <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_op_a  <= w_op_a_nxt;
      r_op_b  <= w_op_b_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_a_nxt  = r_op_a;
    w_op_b_nxt  = r_op_b;
    case (r_state)
      ST_WAIT_A: if (w_press) begin
        w_state_nxt = ST_WAIT_B;
        w_op_a_nxt  = sw;
      end
      ST_WAIT_B: if (w_press) begin
        w_state_nxt = ST_SHOW;
        w_op_b_nxt  = sw;
      end
      ST_SHOW: if (w_press) begin
        w_state_nxt = ST_WAIT_A;
        w_op_a_nxt  = 4'h0;
        w_op_b_nxt  = 4'h0;
      end
      default: w_state_nxt = ST_WAIT_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt   <= '0;
      r_digit_idx <= 2'd0;
    end else if (r_div_cnt == C_DIV_LAST) begin
      r_div_cnt   <= '0;
      r_digit_idx <= r_digit_idx + 2'd1;
    end else begin
      r_div_cnt   <= r_div_cnt + CNT_W'(1);
    end
  end

  // Select what the current slot shows; unlisted slots stay blank.
  always_comb begin
    w_digit_on  = 1'b0;
    w_digit_val = 4'h0;
    case (r_state)
      ST_WAIT_A: if (r_digit_idx == 2'd3) begin
        w_digit_on  = 1'b1;
        w_digit_val = sw;
      end
      ST_WAIT_B: begin
        if (r_digit_idx == 2'd3) begin
          w_digit_on  = 1'b1;
          w_digit_val = r_op_a;
        end else if (r_digit_idx == 2'd2) begin
          w_digit_on  = 1'b1;
          w_digit_val = sw;
        end
      end
      ST_SHOW: begin
        w_digit_on = 1'b1;
        case (r_digit_idx)
          2'd3:    w_digit_val = r_op_a;
          2'd2:    w_digit_val = r_op_b;
          2'd1:    w_digit_val = {3'b000, sum[4]};
          default: w_digit_val = sum[3:0];
        endcase
      end
      default: w_digit_on = 1'b0;
    endcase
  end

  always_comb begin
    w_seg_dec = 7'h7F;
    case (w_digit_val)
      4'h0: w_seg_dec = 7'h40;
      4'h1: w_seg_dec = 7'h79;
      4'h2: w_seg_dec = 7'h24;
      4'h3: w_seg_dec = 7'h30;
      4'h4: w_seg_dec = 7'h19;
      4'h5: w_seg_dec = 7'h12;
      4'h6: w_seg_dec = 7'h02;
      4'h7: w_seg_dec = 7'h78;
      4'h8: w_seg_dec = 7'h00;
      4'h9: w_seg_dec = 7'h10;
      4'hA: w_seg_dec = 7'h08;
      4'hB: w_seg_dec = 7'h03;
      4'hC: w_seg_dec = 7'h46;
      4'hD: w_seg_dec = 7'h21;
      4'hE: w_seg_dec = 7'h06;
      default: w_seg_dec = 7'h0E;
    endcase
  end

  assign op_a  = r_op_a;
  assign op_b  = r_op_b;
  assign sum   = {1'b0, r_op_a} + {1'b0, r_op_b};
  assign state = r_state;
  assign an    = w_digit_on ? ~(4'b0001 << r_digit_idx) : 4'b1111;
  assign seg   = w_digit_on ? w_seg_dec : 7'h7F;

endmodule
`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_seq_ctrl
// Brief    : Directed self-checking bench for adder_seq_ctrl (SCAN_DIV = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       btn;
  logic [3:0] op_a, op_b, an;
  logic [4:0] sum;
  logic [1:0] state;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;
  int tb_cyc;

  adder_seq_ctrl #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .btn   (btn),
    .op_a  (op_a),
    .op_b  (op_b),
    .sum   (sum),
    .state (state),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  // Independent slot reference: cycles since reset release, 4 per slot.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic goto_slot(input int s);
    int n = 0;
    @(negedge clk);
    while (((tb_cyc / 4) % 4) != s && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("slot_timeout", 8'd1, 8'd0);
  endtask

  task automatic check_slot(input string tag, input int s, input logic [3:0] exp_an,
                            input logic [6:0] exp_seg);
    goto_slot(s);
    check({tag, "_an"}, {4'h0, an}, {4'h0, exp_an});
    check({tag, "_seg"}, {1'b0, seg}, {1'b0, exp_seg});
  endtask

  // Button rises before edge k; state must hold after k and k+1, change after k+2.
  task automatic do_press(input string tag, input logic [3:0] v,
                          input logic [1:0] st_old, input logic [1:0] st_new);
    @(negedge clk);
    sw  = v;
    btn = 1'b1;
    @(posedge clk); @(negedge clk);
    check({tag, "_lat1"}, {6'h0, state}, {6'h0, st_old});
    @(posedge clk); @(negedge clk);
    check({tag, "_lat2"}, {6'h0, state}, {6'h0, st_old});
    @(posedge clk); @(negedge clk);
    check({tag, "_upd"}, {6'h0, state}, {6'h0, st_new});
    btn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 1'b1;
    sw    = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_state", {6'h0, state}, 8'h00);
    check("rst_op_a", {4'h0, op_a}, 8'h00);
    check("rst_op_b", {4'h0, op_b}, 8'h00);
    check("rst_sum", {3'h0, sum}, 8'h00);
    check("rst_an", {4'h0, an}, 8'h0F);
    check("rst_seg", {1'b0, seg}, 8'h7F);

    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("held_state", {6'h0, state}, 8'h00);
    check("held_op_a", {4'h0, op_a}, 8'h00);
    btn = 1'b0;
    sw  = 4'h7;
    check_slot("waita_s0", 0, 4'b1111, 7'h7F);
    check_slot("waita_s3", 3, 4'b0111, 7'h78);
    repeat (2) @(negedge clk);

    do_press("load_a", 4'h9, 2'b00, 2'b01);
    check("load_a_val", {4'h0, op_a}, 8'h09);
    do_press("load_b", 4'h8, 2'b01, 2'b10);
    check("load_b_val", {4'h0, op_b}, 8'h08);
    check("sum_98", {3'h0, sum}, 8'h11);

    check_slot("show98_s0", 0, 4'b1110, 7'h79);
    check_slot("show98_s1", 1, 4'b1101, 7'h79);
    check_slot("show98_s2", 2, 4'b1011, 7'h00);
    check_slot("show98_s3", 3, 4'b0111, 7'h10);

    do_press("clr1", 4'h0, 2'b10, 2'b00);
    do_press("max_a", 4'hF, 2'b00, 2'b01);
    do_press("max_b", 4'hF, 2'b01, 2'b10);
    check("sum_ff", {3'h0, sum}, 8'h1E);
    check_slot("showff_s1", 1, 4'b1101, 7'h79);
    check_slot("showff_s0", 0, 4'b1110, 7'h06);

    do_press("clr2", 4'h0, 2'b10, 2'b00);
    do_press("wb_a", 4'h3, 2'b00, 2'b01);
    sw = 4'hC;
    check_slot("waitb_s0", 0, 4'b1111, 7'h7F);
    check_slot("waitb_s1", 1, 4'b1111, 7'h7F);
    check_slot("waitb_s2", 2, 4'b1011, 7'h46);
    check_slot("waitb_s3", 3, 4'b0111, 7'h30);
    do_press("wb_b", 4'hC, 2'b01, 2'b10);
    do_press("wb_clr", 4'h0, 2'b10, 2'b00);
    check("wb_clr_a", {4'h0, op_a}, 8'h00);
    check("wb_clr_b", {4'h0, op_b}, 8'h00);

    @(negedge clk);
    sw  = 4'h5;
    btn = 1'b1;
    repeat (20) @(negedge clk);
    check("hold20_state", {6'h0, state}, 8'h01);
    check("hold20_op_a", {4'h0, op_a}, 8'h05);
    btn = 1'b0;
    repeat (3) @(negedge clk);
    do_press("mr_b", 4'h6, 2'b01, 2'b10);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_state", {6'h0, state}, 8'h00);
    check("midrst_op_a", {4'h0, op_a}, 8'h00);
    check("midrst_an", {4'h0, an}, 8'h0F);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_state", {6'h0, state}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
